// File: rtl/filter_scan_pkg.sv
// Shared definitions for the 3x3 filter frame sequencer: FSM state encoding
// and the default frame geometry also used by the filters' window bounds.
package filter_scan_pkg;

    localparam int unsigned DEF_WIDTH    = 1600;
    localparam int unsigned DEF_HEIGHT   = 900;
    localparam int unsigned DEF_PIPE_LAT = 2;
    localparam int unsigned DEF_XW       = 12;
    localparam int unsigned DEF_YW       = 12;
    localparam int unsigned DEF_CW       = 21;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of filter outputs expected for one frame.
    function automatic int unsigned frame_beats(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/filter_scan_xy_counter.sv
// Raster coordinate generator: advances POSX/POSY once per issued beat,
// wraps at end of line and holds on the final pixel of the frame.
module filter_scan_xy_counter #(
    parameter int unsigned WIDTH  = 1600,
    parameter int unsigned HEIGHT = 900,
    parameter int unsigned XW     = 12,
    parameter int unsigned YW     = 12
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] posx,
    output logic [YW-1:0] posy,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    logic end_of_line;

    // End-of-line and final-pixel decodes of the current coordinate.
    assign end_of_line = (posx == X_MAX);
    assign last        = end_of_line && (posy == Y_MAX);

    // Coordinate register: cleared between frames, frozen after the last beat.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            posx <= '0;
            posy <= '0;
        end else if (advance && !last) begin
            if (end_of_line) begin
                posx <= '0;
                posy <= posy + YW'(1);
            end else begin
                posx <= posx + XW'(1);
            end
        end
    end

endmodule

// File: rtl/filter_scan_ctrl.sv
// Frame sequencer for the 3x3 line-buffered filters. Issues one READY beat
// per pixel with its coordinate, throttled by upstream empty and downstream
// programmable-full, then waits for every filter WREN before pulsing DONE.
// Optional build macro FILTER_SCAN_STATS_EN adds STALL_CNT and FRAME_CNT.
module filter_scan_ctrl
    import filter_scan_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned HEIGHT   = DEF_HEIGHT,
    parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
    parameter int unsigned XW       = DEF_XW,
    parameter int unsigned YW       = DEF_YW,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    input  logic          SRC_EMPTY,
    input  logic          DST_PFULL,
    output logic          READY,
    output logic [XW-1:0] POSX,
    output logic [YW-1:0] POSY,
    input  logic          FLT_WREN
`ifdef FILTER_SCAN_STATS_EN
    ,
    output logic [31:0]   STALL_CNT,
    output logic [15:0]   FRAME_CNT
`endif
);

    localparam int unsigned TOTAL = frame_beats(WIDTH, HEIGHT);

    // Elaboration-time sanity of the geometry against the chosen widths.
    if ($clog2(TOTAL + 1) > CW) begin : g_cw_too_small
        $error("CW cannot hold WIDTH*HEIGHT");
    end
    if ($clog2(WIDTH) > XW) begin : g_xw_too_small
        $error("XW cannot hold WIDTH-1");
    end
    if ($clog2(HEIGHT) > YW) begin : g_yw_too_small
        $error("YW cannot hold HEIGHT-1");
    end
    if (PIPE_LAT == 0) begin : g_lat_zero
        $error("filter READY-to-WREN latency must be at least one cycle");
    end

    state_t        state;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] out_cnt_next;
    logic          wren_seen;
    logic          last_pixel;
    logic          xy_clear;

    // A beat is issued only while scanning and both FIFOs allow it; the
    // filter pipeline cannot stall, so room is checked before issue.
    assign READY = (state == ST_RUN) && !SRC_EMPTY && !DST_PFULL;

    // Filter outputs are only counted inside a frame.
    assign wren_seen    = FLT_WREN && BUSY;
    assign out_cnt_next = out_cnt + CW'(wren_seen);

    // Coordinates return to the origin once a frame has finished.
    assign xy_clear = (state == ST_IDLE) || (state == ST_DONE);

    filter_scan_xy_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_xy (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (xy_clear),
        .advance (READY),
        .posx    (POSX),
        .posy    (POSY),
        .last    (last_pixel)
    );

    // Sequencer FSM with registered BUSY/DONE and the output beat counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            out_cnt <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state   <= ST_RUN;
                        BUSY    <= 1'b1;
                        out_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    out_cnt <= out_cnt_next;
                    if (READY && last_pixel) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    out_cnt <= out_cnt_next;
                    // Include this cycle's WREN so DONE follows the last one by a cycle.
                    if (out_cnt_next == CW'(TOTAL)) begin
                        state <= ST_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FILTER_SCAN_STATS_EN
    // Throttle and frame statistics for host-side performance monitoring.
    always_ff @(posedge CLK) begin
        if (RST) begin
            STALL_CNT <= '0;
            FRAME_CNT <= '0;
        end else begin
            if ((state == ST_IDLE) && START) begin
                STALL_CNT <= '0;
            end else if ((state == ST_RUN) && !READY && (STALL_CNT != '1)) begin
                STALL_CNT <= STALL_CNT + 32'd1;
            end
            if (DONE) begin
                FRAME_CNT <= FRAME_CNT + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Self-checking bench for filter_scan_ctrl on a small 8x4 frame with a
// behavioural frame model and a 2-cycle filter emulation driving FLT_WREN.
module tb_filter_scan_ctrl;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int LAT = 2;
    localparam int TOT = W * H;
    localparam int XWB = 3;
    localparam int YWB = 2;
    localparam int CWB = 6;

    logic           CLK       = 1'b0;
    logic           RST       = 1'b1;
    logic           START     = 1'b0;
    logic           SRC_EMPTY = 1'b0;
    logic           DST_PFULL = 1'b0;
    logic           FLT_WREN  = 1'b0;
    logic           BUSY;
    logic           DONE;
    logic           READY;
    logic [XWB-1:0] POSX;
    logic [YWB-1:0] POSY;
`ifdef FILTER_SCAN_STATS_EN
    logic [31:0]    STALL_CNT;
    logic [15:0]    FRAME_CNT;
`endif

    filter_scan_ctrl #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .PIPE_LAT (LAT),
        .XW       (XWB),
        .YW       (YWB),
        .CW       (CWB)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .SRC_EMPTY (SRC_EMPTY),
        .DST_PFULL (DST_PFULL),
        .READY     (READY),
        .POSX      (POSX),
        .POSY      (POSY),
        .FLT_WREN  (FLT_WREN)
`ifdef FILTER_SCAN_STATS_EN
        ,
        .STALL_CNT (STALL_CNT),
        .FRAME_CNT (FRAME_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int       n_checks = 0;
    int       n_errors = 0;

    // Frame model: a frame is a count of issued beats and received outputs.
    bit       model_valid = 1'b0;
    bit       m_busy      = 1'b0;
    bit       m_done_due  = 1'b0;
    int       m_beats     = 0;
    int       m_wrens     = 0;
    int       m_stall     = 0;
    int       m_frames    = 0;
    logic [1:0] rdy_hist  = 2'b00;

    int       cyc           = 0;
    int       beat_seen     = 0;
    int       done_seen     = 0;
    int       last_beat_cyc = 0;
    int       done_cyc      = 0;
    int       last_wren_cyc = 0;
    int       frames_before = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check outputs at the falling edge, advance model.
    task automatic step(input bit st, input bit emp, input bit pf, input bit rs);
        bit exp_ready;
        bit wren;
        int k;
        int exp_x;
        int exp_y;
        START     = st;
        SRC_EMPTY = emp;
        DST_PFULL = pf;
        RST       = rs;
        wren      = rdy_hist[1];
        FLT_WREN  = wren;
        @(negedge CLK);
        exp_ready = m_busy && (m_beats < TOT) && !emp && !pf;
        k     = (m_beats < TOT) ? m_beats : TOT - 1;
        exp_x = (m_busy || m_done_due) ? (k % W) : 0;
        exp_y = (m_busy || m_done_due) ? (k / W) : 0;
        if (model_valid) begin
            check("ready", 64'(READY), 64'(exp_ready));
            check("busy",  64'(BUSY),  64'(m_busy));
            check("done",  64'(DONE),  64'(m_done_due));
            check("posx",  64'(POSX),  64'(exp_x));
            check("posy",  64'(POSY),  64'(exp_y));
`ifdef FILTER_SCAN_STATS_EN
            check("stall_cnt", 64'(STALL_CNT), 64'(m_stall));
            check("frame_cnt", 64'(FRAME_CNT), 64'(m_frames));
`endif
        end
        if (READY === 1'b1) begin
            beat_seen++;
            last_beat_cyc = cyc;
        end
        if (DONE === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (rs) begin
            model_valid = 1'b1;
            m_busy      = 1'b0;
            m_done_due  = 1'b0;
            m_beats     = 0;
            m_wrens     = 0;
            m_stall     = 0;
            m_frames    = 0;
            rdy_hist    = 2'b00;
        end else begin
            if (m_done_due) begin
                m_done_due = 1'b0;
                m_frames++;
            end else if (!m_busy) begin
                if (st) begin
                    m_busy  = 1'b1;
                    m_beats = 0;
                    m_wrens = 0;
                    m_stall = 0;
                end
            end else begin
                if (m_beats < TOT && !exp_ready) m_stall++;
                if (exp_ready) m_beats++;
                if (wren) begin
                    m_wrens++;
                    if (m_wrens == TOT) last_wren_cyc = cyc;
                end
                if (m_beats == TOT && m_wrens == TOT) begin
                    m_busy     = 1'b0;
                    m_done_due = 1'b1;
                end
            end
            rdy_hist = {rdy_hist[0], READY};
        end
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    // Start a frame and drive it to completion with the selected stimulus pattern.
    task automatic run_frame(input int mode, input int budget);
        int n;
        int pf_left;
        bit pf_armed;
        bit st;
        bit emp;
        bit pf;
        bit rs;
        beat_seen = 0;
        done_seen = 0;
        pf_left   = 0;
        pf_armed  = 1'b0;
        n         = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        while ((m_busy || m_done_due) && n < budget) begin
            st  = 1'b0;
            emp = 1'b0;
            pf  = 1'b0;
            rs  = 1'b0;
            case (mode)
                1: emp = n[0];
                2: begin
                    if (!pf_armed && m_beats == 10) begin
                        pf_left  = 20;
                        pf_armed = 1'b1;
                    end
                    if (pf_left > 0) begin
                        pf = 1'b1;
                        pf_left--;
                    end
                end
                3: begin
                    emp = ($urandom_range(0, 3) == 0);
                    pf  = ($urandom_range(0, 4) == 0);
                end
                4: st = (m_busy && m_beats == 5) || m_done_due;
                5: rs = m_busy && (m_beats == 17);
                default: ;
            endcase
            step(st, emp, pf, rs);
            n++;
            if (mode == 2 && pf_armed && pf_left == 1) begin
                check("stall_hold_x", 64'(POSX), 64'(2));
                check("stall_hold_y", 64'(POSY), 64'(1));
            end
        end
        check("frame_timeout", 64'(n >= budget), 64'(0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("rst_ready", 64'(READY), 64'(0));
        check("rst_posx",  64'(POSX),  64'(0));
        check("rst_posy",  64'(POSY),  64'(0));

        // Free-running frame: back-to-back beats, DONE LAT+1 after last beat.
        run_frame(0, 200);
        check("t1_beats",    64'(beat_seen), 64'(TOT));
        check("t1_done_cnt", 64'(done_seen), 64'(1));
        check("t1_done_lat", 64'(done_cyc - last_beat_cyc), 64'(LAT + 1));
        idle(3);

        // Upstream empty every other cycle.
        run_frame(1, 400);
        check("t2_beats",       64'(beat_seen), 64'(TOT));
        check("t2_done_cnt",    64'(done_seen), 64'(1));
        check("t2_done_after",  64'(done_cyc - last_wren_cyc), 64'(1));
        idle(2);

        // Downstream full for 20 cycles starting at beat 10.
        run_frame(2, 400);
        check("t3_beats",    64'(beat_seen), 64'(TOT));
        check("t3_done_cnt", 64'(done_seen), 64'(1));
`ifdef FILTER_SCAN_STATS_EN
        check("t3_stall_cnt", 64'(STALL_CNT), 64'(20));
`endif
        idle(2);

        // START during RUN and in the DONE cycle must both be ignored.
        frames_before = m_frames;
        run_frame(4, 400);
        idle(5);
        check("t4_beats",    64'(beat_seen), 64'(TOT));
        check("t4_done_cnt", 64'(done_seen), 64'(1));
        check("t4_idle",     64'(BUSY),      64'(0));
`ifdef FILTER_SCAN_STATS_EN
        check("t4_frame_cnt", 64'(FRAME_CNT), 64'(frames_before + 1));
`endif

        // Reset in mid-frame, then a clean rescan from the origin.
        run_frame(5, 400);
        check("t5_rst_ready", 64'(READY),     64'(0));
        check("t5_rst_busy",  64'(BUSY),      64'(0));
        check("t5_rst_posx",  64'(POSX),      64'(0));
        check("t5_rst_posy",  64'(POSY),      64'(0));
        check("t5_no_done",   64'(done_seen), 64'(0));
        run_frame(0, 200);
        check("t5_beats",     64'(beat_seen), 64'(TOT));
        check("t5_done_cnt",  64'(done_seen), 64'(1));
        check("t5_done_lat",  64'(done_cyc - last_beat_cyc), 64'(LAT + 1));
        idle(2);

        // Random throttling on both FIFOs.
        for (int f = 0; f < 4; f++) begin
            run_frame(3, 800);
            check("rnd_beats",    64'(beat_seen), 64'(TOT));
            check("rnd_done_cnt", 64'(done_seen), 64'(1));
            idle(1 + f);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/filter_scan_ctrl.md
Name: filter_scan_ctrl

Overview:
Frame sequencer for the 3x3 line-buffered image filters (sobel and siblings).
- Pulls pixels from the upstream pixel FIFO and presents each pixel's POSX/POSY coordinate to the filter with its READY strobe.
- Throttles issue against downstream FIFO room, because the filter pipeline cannot stall.
- Counts filter WREN outputs and signals frame completion to the host control logic.
- Sits between the input pixel FIFO, the filter instance and the output pixel FIFO.

Parameters:
- WIDTH, 1600, pixels per line.
- HEIGHT, 900, lines per frame.
- PIPE_LAT, 2, filter READY-to-WREN latency in cycles.
- XW, 12, POSX width.
- YW, 12, POSY width.
- CW, 21, output beat counter width; must hold WIDTH*HEIGHT.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  one-cycle pulse; begins a frame scan.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse when all WIDTH*HEIGHT outputs have been written.
- SRC_EMPTY  in  1  upstream pixel FIFO empty.
- DST_PFULL  in  1  downstream FIFO programmable-full; asserted with at least PIPE_LAT+1 free entries remaining.
- READY  out  1  to filter READY; doubles as upstream FIFO rd_en.
- POSX  out  XW  coordinate of the pixel issued with READY.
- POSY  out  YW  coordinate of the pixel issued with READY.
- FLT_WREN  in  1  filter WREN; observed only, since the filter drives the downstream FIFO directly.

Behaviour:
- Reset values: state IDLE, READY=0, BUSY=0, DONE=0, POSX=0, POSY=0, out count=0.
- States:
  - IDLE: START -> RUN. POSX/POSY cleared to 0. START is ignored in every state other than IDLE.
  - RUN: READY = !SRC_EMPTY && !DST_PFULL, combinational from the registered state. Each cycle with READY=1 is one beat.
  - DRAIN: READY=0. Wait until out count == WIDTH*HEIGHT -> DONE.
  - DONE: DONE=1 for exactly one cycle, BUSY=0 -> IDLE. A START in this cycle is ignored.
- POSX/POSY: registered; valid in the same cycle as the beat they describe.
  - After a beat: POSX==WIDTH-1 -> POSX=0, POSY+1; otherwise POSX+1.
  - Beat at (WIDTH-1, HEIGHT-1) -> DRAIN next cycle. POSX/POSY hold at the last coordinate; they do not wrap to 0.
- Out count increments on FLT_WREN while BUSY. FLT_WREN in IDLE is ignored.
- Exactly WIDTH*HEIGHT beats are issued per frame. Stalls may occur mid-line and on any cycle; there are no extra beats.
- DST_PFULL and SRC_EMPTY high in the same cycle: no beat. Both deassert: beat in that same cycle.
- RST mid-frame: everything returns to IDLE next cycle and in-flight WRENs are discarded. The filter line FIFOs share the same RST, so the next frame starts clean.
- Latency: START -> first possible READY = 1 cycle. Last beat -> DONE = PIPE_LAT+1 cycles minimum.

Optional Feature:
- Macro FILTER_SCAN_STATS_EN.
- When defined, adds two outputs:
  - STALL_CNT (32 bit): counts RUN cycles with READY=0; cleared on START accept; saturates at all-ones.
  - FRAME_CNT (16 bit): increments on DONE; wraps.
  - Both reset to 0.
- When undefined, neither port exists and there is no added logic.

Decomposition:
- Package filter_scan_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - default WIDTH/HEIGHT/PIPE_LAT constants shared with the filters' Within window bounds.
- One natural sub-module: filter_scan_xy_counter (POSX/POSY advance, wrap and last-beat flag).
- Throttle logic and FSM stay in the top.

Test Plan:
- WIDTH=8, HEIGHT=4, PIPE_LAT=2, SRC_EMPTY=0, DST_PFULL=0, START -> 32 consecutive READY beats. POSX sequence 0..7 repeats, POSY 0..3. DONE pulse 3 cycles after the last beat; BUSY spans the whole frame.
- Same config, SRC_EMPTY toggled every other cycle -> still exactly 32 beats with no duplicate or skipped coordinates. DONE follows the 32nd FLT_WREN by 1 cycle.
- DST_PFULL held high from beat 10 for 20 cycles -> READY=0 throughout, POSX/POSY hold at (2,1). Resume issues (2,1) next. STATS build: STALL_CNT=20.
- START pulsed during RUN and again in the DONE cycle -> both ignored; only one frame is scanned; FRAME_CNT=1.
- RST asserted at beat 17 -> next cycle IDLE, READY=0, POSX=POSY=0. New START rescans all 32 beats from (0,0) with out count starting from 0.
- Model FLT_WREN as READY delayed 2 cycles, default 1600x900 -> 1,440,000 beats; DONE exactly once; out count does not overflow at CW=21.
